alu_cmd_master: RTL and testbench

Bus initiator that programs the memory-mapped ALU register file (A, B, OP, EXEC at addresses 0-3) and collects the result. It accepts one operation at a time on a valid/ready command port, issues the register writes toward the memory write port in fixed order, and pulses EXEC. It then waits for the ALU result, clears EXEC, and returns the result on a valid/ready response port. It sits upstream of the memory, in the direction opposite to the memory-to-ALU wiring.

---
 rtl/alu_cmd_master.sv | 183 ++++++++++++++++++
 tb/tb_alu_cmd_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_master.sv
// rtl/alu_cmd_master.sv - bus initiator that programs the ALU register file and returns the result
//
// Takes one operation at a time on the cmd port. Writes A (addr 0), B (addr 1),
// OP (addr 2) and EXEC=1 (addr 3) toward memory, waits for alu_done or a timeout,
// writes EXEC=0, then holds the result on the rsp port until it is accepted.
// All outputs are registered: each is loaded from the decode of the next state.
//
// Optional feature macro: ALU_CMD_OPCACHE_EN. When it is defined, operand and
// opcode writes whose values already sit in memory are skipped.
//
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; cmd_a, cmd_b, cmd_op are the operands
//   mem_we/addr/wdata       memory write port toward the ALU register file
//   alu_done, alu_res       ALU completion strobe and 2*DATA_WIDTH result
//   rsp_valid/rsp_ready     response handshake; rsp_res result, rsp_err timeout flag
//   busy                    high whenever the FSM is not in IDLE
module alu_cmd_master #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [DATA_WIDTH-1:0]   cmd_a,
   input  logic [DATA_WIDTH-1:0]   cmd_b,
   input  logic [2:0]              cmd_op,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    alu_done,
   input  logic [2*DATA_WIDTH-1:0] alu_res,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [2*DATA_WIDTH-1:0] rsp_res,
   output logic                    rsp_err,
   output logic                    busy
);

   typedef enum logic [2:0] {
      IDLE, WR_A, WR_B, WR_OP, WR_EXEC, WAIT, CLR_EXEC, RESP
   } state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t                  state, nxt;
   logic [DATA_WIDTH-1:0]   a_q, b_q, src_a, src_b;
   logic [2:0]              op_q, src_op;
   logic [CW-1:0]           cnt;
   logic [2*DATA_WIDTH-1:0] res_q;
   logic                    err_q;
   logic                    timed_out;
   logic                    need_a, need_b, need_op;
   logic                    nx_we;
   logic [ADDR_WIDTH-1:0]   nx_addr;
   logic [DATA_WIDTH-1:0]   nx_wdata;

   // Outputs are computed from the next state, so on the accept edge the
   // operands have not been latched yet; take them straight from the cmd port.
   assign src_a  = (state == IDLE) ? cmd_a  : a_q;
   assign src_b  = (state == IDLE) ? cmd_b  : b_q;
   assign src_op = (state == IDLE) ? cmd_op : op_q;

   assign timed_out = (cnt == CW'(TIMEOUT - 1));

`ifdef ALU_CMD_OPCACHE_EN
   logic [DATA_WIDTH-1:0] c_a, c_b;
   logic [2:0]            c_op;
   logic                  c_valid;

   assign need_a  = !(c_valid && (c_a  == src_a));
   assign need_b  = !(c_valid && (c_b  == src_b));
   assign need_op = !(c_valid && (c_op == src_op));

   // The cache mirrors memory: a field updates in the cycle its write is on the
   // bus; the valid flag is set once a full sequence has reached EXEC.
   always_ff @(posedge clk) begin
      if (!reset) begin
         c_valid <= 1'b0;
         c_a     <= '0;
         c_b     <= '0;
         c_op    <= '0;
      end else begin
         case (state)
            WR_A:    c_a     <= a_q;
            WR_B:    c_b     <= b_q;
            WR_OP:   c_op    <= op_q;
            WR_EXEC: c_valid <= 1'b1;
            default: ;
         endcase
      end
   end
`else
   assign need_a  = 1'b1;
   assign need_b  = 1'b1;
   assign need_op = 1'b1;
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (cmd_valid && cmd_ready)
                      nxt = need_a ? WR_A : need_b ? WR_B : need_op ? WR_OP : WR_EXEC;
         WR_A:     nxt = need_b ? WR_B : need_op ? WR_OP : WR_EXEC;
         WR_B:     nxt = need_op ? WR_OP : WR_EXEC;
         WR_OP:    nxt = WR_EXEC;
         WR_EXEC:  nxt = WAIT;
         WAIT:     if (alu_done || timed_out) nxt = CLR_EXEC;
         CLR_EXEC: nxt = RESP;
         RESP:     if (rsp_ready) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   always_comb begin
      nx_we    = 1'b0;
      nx_addr  = '0;
      nx_wdata = '0;
      case (nxt)
         WR_A:     begin nx_we = 1'b1; nx_addr = ADDR_WIDTH'(0); nx_wdata = src_a; end
         WR_B:     begin nx_we = 1'b1; nx_addr = ADDR_WIDTH'(1); nx_wdata = src_b; end
         WR_OP:    begin nx_we = 1'b1; nx_addr = ADDR_WIDTH'(2); nx_wdata = DATA_WIDTH'(src_op); end
         WR_EXEC:  begin nx_we = 1'b1; nx_addr = ADDR_WIDTH'(3); nx_wdata = DATA_WIDTH'(1); end
         CLR_EXEC: begin nx_we = 1'b1; nx_addr = ADDR_WIDTH'(3); nx_wdata = '0; end
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         cnt       <= '0;
         res_q     <= '0;
         err_q     <= 1'b0;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_res   <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= nxt;
         cmd_ready <= (nxt == IDLE);
         busy      <= (nxt != IDLE);
         mem_we    <= nx_we;
         mem_addr  <= nx_addr;
         mem_wdata <= nx_wdata;
         rsp_valid <= (nxt == RESP);
         rsp_res   <= (nxt == RESP) ? res_q : '0;
         rsp_err   <= (nxt == RESP) && err_q;

         if (state == IDLE && cmd_valid && cmd_ready) begin
            a_q  <= cmd_a;
            b_q  <= cmd_b;
            op_q <= cmd_op;
         end

         if (state == WR_EXEC)
            cnt <= '0;
         else if (state == WAIT)
            cnt <= cnt + 1'b1;

         // alu_done is checked first so it wins over a timeout in the same cycle.
         if (state == WAIT) begin
            if (alu_done) begin
               res_q <= alu_res;
               err_q <= 1'b0;
            end else if (timed_out) begin
               res_q <= '0;
               err_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_master.sv
// tb/tb_alu_cmd_master.sv - scoreboard bench for alu_cmd_master
module tb_alu_cmd_master;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [DW-1:0] cmd_a = '0;
   logic [DW-1:0] cmd_b = '0;
   logic [2:0]    cmd_op = '0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          alu_done = 1'b0;
   logic [2*DW-1:0] alu_res = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [2*DW-1:0] rsp_res;
   logic          rsp_err;
   logic          busy;

   always #5 clk = ~clk;

   alu_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .alu_done(alu_done), .alu_res(alu_res),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_res(rsp_res), .rsp_err(rsp_err),
      .busy(busy)
   );

   typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
   typedef struct packed { logic [2*DW-1:0] res; logic err; } rsp_t;

   wr_t  exp_wr[$];
   rsp_t exp_rsp[$];

   int checks = 0;
   int failures = 0;

   // bench-side model of the write cache (used only when the feature is built)
   logic [DW-1:0] ca = '0, cb = '0;
   logic [2:0]    cop = '0;
   bit            cvalid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // monitor: pops expected writes/responses whenever the DUT presents them
   always @(negedge clk) begin
      wr_t  w;
      rsp_t r;
      if (mem_we === 1'b1) begin
         if (exp_wr.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write", mem_addr, mem_wdata);
         end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(w.addr));
            chk("wr_data", 32'(mem_wdata), 32'(w.data));
         end
      end
      if (rsp_valid === 1'b1) begin
         if (exp_rsp.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp actual=0x%0h required=no response", rsp_res);
         end else begin
            r = exp_rsp[0];
            chk("rsp_res", 32'(rsp_res), 32'(r.res));
            chk("rsp_err", 32'(rsp_err), 32'(r.err));
            if (rsp_ready === 1'b1) r = exp_rsp.pop_front();
         end
      end
   end

   // One full operation. done_at: WAIT cycle (1-based) in which alu_done is
   // driven, 0 for none. hold: RESP cycles with rsp_ready low while a further
   // command is offered. pre: the command must be accepted in the current cycle.
   task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] op,
                         input int done_at, input logic [2*DW-1:0] res,
                         input int hold, input bit pre);
      int  n, nw, wlen;
      bit  wa, wb, wo;
      wa = 1'b1; wb = 1'b1; wo = 1'b1;
`ifdef ALU_CMD_OPCACHE_EN
      wa = !(cvalid && ca == a);
      wb = !(cvalid && cb == b);
      wo = !(cvalid && cop == op);
`endif
      nw   = int'(wa) + int'(wb) + int'(wo) + 1;
      wlen = (done_at > 0) ? done_at : TO;

      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      if (pre) chk("accept_immediate", 32'(cmd_ready), 1);
      n = 0;
      while (cmd_ready !== 1'b1 && n < 40) begin step(); n++; end
      if (cmd_ready !== 1'b1) begin
         chk("cmd_ready_wait", 32'(cmd_ready), 1);
         cmd_valid = 1'b0;
         return;
      end

      if (wa) exp_wr.push_back('{addr: AW'(0), data: a});
      if (wb) exp_wr.push_back('{addr: AW'(1), data: b});
      if (wo) exp_wr.push_back('{addr: AW'(2), data: DW'(op)});
      exp_wr.push_back('{addr: AW'(3), data: DW'(1)});
      exp_wr.push_back('{addr: AW'(3), data: DW'(0)});
      if (done_at > 0) exp_rsp.push_back('{res: res, err: 1'b0});
      else             exp_rsp.push_back('{res: '0, err: 1'b1});

      step();                                   // cycle 1
      cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; cmd_op = ~op;
      chk("busy_writing", 32'(busy), 1);
      chk("cmd_ready_writing", 32'(cmd_ready), 0);
      for (int i = 0; i < nw; i++) begin        // alu_done noise during writes
         alu_done = 1'b1; alu_res = 16'hdead;
         step();
      end
      alu_done = 1'b0;                          // first WAIT cycle
      chk("we_wait", 32'(mem_we), 0);
      for (int i = 1; i < wlen; i++) step();    // last WAIT cycle
      chk("we_last_wait", 32'(mem_we), 0);
      if (done_at > 0) begin alu_done = 1'b1; alu_res = res; end
      step();                                   // CLR_EXEC
      alu_done = 1'b0; alu_res = '0;
      chk("we_clr", 32'(mem_we), 1);
      chk("rsp_valid_clr", 32'(rsp_valid), 0);
      step();                                   // RESP
      chk("rsp_valid_rise", 32'(rsp_valid), 1);
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1; cmd_a = 8'hee; cmd_b = 8'hee; cmd_op = 3'd7;
         chk("cmd_ready_resp", 32'(cmd_ready), 0);
         step();
         chk("rsp_valid_hold", 32'(rsp_valid), 1);
      end
      rsp_ready = 1'b1;
      step();                                   // IDLE
      rsp_ready = 1'b0;
      chk("rsp_valid_after", 32'(rsp_valid), 0);
      chk("cmd_ready_idle", 32'(cmd_ready), 1);
      chk("busy_idle", 32'(busy), 0);
      if (hold == 0) cmd_valid = 1'b0;
      ca = a; cb = b; cop = op; cvalid = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      // reset state
      reset = 1'b0;
      step(); step(); step();
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_res", 32'(rsp_res), 0);
      reset = 1'b1;
      step();
      chk("ready_after_rst", 32'(cmd_ready), 1);

      // basic op: alu_done in the 3rd WAIT cycle, response in cycle 9
      run_op(8'h12, 8'h34, 3'd3, 3, 16'h0046, 0, 1'b0);
      // timeout: 16 WAIT cycles, res 0, err 1
      run_op(8'h21, 8'h43, 3'd5, 0, 16'h0000, 0, 1'b0);
      // alu_done in the final timeout cycle wins
      run_op(8'h07, 8'h09, 3'd1, TO, 16'h003f, 0, 1'b0);
      // backpressure with a second command offered, then accepted at once
      run_op(8'h80, 8'h02, 3'd2, 1, 16'h0100, 5, 1'b0);
      run_op(8'h11, 8'h22, 3'd4, 2, 16'h0033, 0, 1'b1);

      // reset during WR_B
      cmd_a = 8'h5a; cmd_b = 8'ha5; cmd_op = 3'd6; cmd_valid = 1'b1;
      chk("rst_seq_ready", 32'(cmd_ready), 1);
      exp_wr.push_back('{addr: AW'(0), data: 8'h5a});
      exp_wr.push_back('{addr: AW'(1), data: 8'ha5});
      step();                                   // WR_A
      cmd_valid = 1'b0;
      step();                                   // WR_B
      chk("rst_seq_wr_b", 32'(mem_addr), 1);
      reset = 1'b0;
      step();
      chk("midrst_we", 32'(mem_we), 0);
      chk("midrst_addr", 32'(mem_addr), 0);
      chk("midrst_wdata", 32'(mem_wdata), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_cmd_ready", 32'(cmd_ready), 0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 0);
      chk("midrst_rsp_err", 32'(rsp_err), 0);
      chk("midrst_wr_drained", exp_wr.size(), 0);
      cvalid = 1'b0;
      reset = 1'b1;
      step(); step();
      chk("midrst_no_late_write", 32'(mem_we), 0);
      run_op(8'h33, 8'h44, 3'd7, 1, 16'h1234, 0, 1'b0);

`ifdef ALU_CMD_OPCACHE_EN
      run_op(8'h66, 8'h77, 3'd2, 1, 16'h00dd, 0, 1'b0);
      run_op(8'h66, 8'h77, 3'd2, 1, 16'h00de, 0, 1'b0);
      run_op(8'h66, 8'h78, 3'd2, 1, 16'h00df, 0, 1'b0);
`endif

      step();
      chk("wr_queue_empty", exp_wr.size(), 0);
      chk("rsp_queue_empty", exp_rsp.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
